// File: rtl/npu_i2c_mac.sv
// I2C read master + signed 8x8 MAC: fetches 2*VEC_LEN bytes (a,w pairs), accumulates the dot product, shows a window on LEDs.
// Latency: roughly (1 + 9 + 18*VEC_LEN + 1.5) bit periods of 4*CLK_DIV cycles from accepted start to done.
// Backpressure: none; start is ignored while busy, stop aborts at the next quarter-bit boundary.
module npu_i2c_mac #(
    parameter int         VEC_LEN   = 4,
    parameter int         CLK_DIV   = 4,
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         ACC_W     = 24,
    parameter int         LED_W     = 8,
    parameter int         LED_SHIFT = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             relu_en,
    input  logic             SDA_in,
    output logic             SDA,
    output logic             SCL,
    output logic [LED_W-1:0] LEDs,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [8:0]    LAST_BYTE = 9'(2 * VEC_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_READ,
        S_MACK,
        S_STOP
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [2:0]              phase_q;     // quarter index; STOP uses 0..5
    logic [2:0]              bit_q;
    logic [8:0]              byte_q;
    logic [7:0]              sh_q;        // address out / data in shift register
    logic signed [7:0]       a_q;         // held activation byte
    logic signed [ACC_W-1:0] acc_q;
    logic                    relu_q;
    logic                    abort_q;     // abort requested during this job
    logic                    sda_q;
    logic                    scl_q;
    logic [LED_W-1:0]        leds_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    logic                    qend;
    logic                    active;
    logic                    abort_now;
    logic                    last_byte;
    logic signed [15:0]      prod;
    logic signed [ACC_W-1:0] acc_d;

    // Quarter-bit boundary, abort decision and the MAC datapath
    always_comb begin
        qend      = (cnt_q == CNT_MAX);
        active    = (state_q == S_START) || (state_q == S_ADDR) || (state_q == S_ADDR_ACK) ||
                    (state_q == S_READ)  || (state_q == S_MACK);
        abort_now = active && (abort_q || stop);
        last_byte = (byte_q == LAST_BYTE);
        prod      = a_q * $signed(sh_q);
        acc_d     = acc_q + ACC_W'(prod);
    end

    // Bus sequencer: all state and bus/status outputs are registered here
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            relu_q  <= 1'b0;
            abort_q <= 1'b0;
            sda_q   <= 1'b1;
            scl_q   <= 1'b1;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            cnt_q   <= '0;
            phase_q <= '0;
            abort_q <= 1'b0;
            if (start && !stop) begin
                acc_q   <= '0;
                done_q  <= 1'b0;
                error_q <= 1'b0;
                relu_q  <= relu_en;
                busy_q  <= 1'b1;
                state_q <= S_START;
            end
        end else begin
            cnt_q <= qend ? '0 : cnt_q + CW'(1);
            // A short stop pulse is remembered until the next boundary
            if (active && stop) begin
                abort_q <= 1'b1;
            end
            if (qend) begin
                phase_q <= phase_q + 3'd1;
                if (abort_now) begin
                    state_q <= S_STOP;
                    phase_q <= '0;
                    scl_q   <= 1'b0;
                    sda_q   <= 1'b0;
                    abort_q <= 1'b1;
                end else begin
                    case (state_q)
                        S_START: begin
                            if (phase_q == 3'd1) begin
                                sda_q <= 1'b0;
                            end
                            if (phase_q == 3'd3) begin
                                state_q <= S_ADDR;
                                phase_q <= '0;
                                bit_q   <= '0;
                                scl_q   <= 1'b0;
                                sh_q    <= {DEV_ADDR, 1'b1};
                                sda_q   <= DEV_ADDR[6];
                            end
                        end
                        S_ADDR, S_ADDR_ACK, S_READ, S_MACK: begin
                            if (phase_q == 3'd1) begin
                                scl_q <= 1'b1;
                            end
                            // Sample the slave on the last cycle of the high-going quarter
                            if ((phase_q == 3'd2) && ((state_q == S_ADDR_ACK) || (state_q == S_READ))) begin
                                sh_q <= {sh_q[6:0], SDA_in};
                            end
                            if (phase_q == 3'd3) begin
                                phase_q <= '0;
                                scl_q   <= 1'b0;
                                if (state_q == S_ADDR) begin
                                    bit_q <= bit_q + 3'd1;
                                    if (bit_q == 3'd7) begin
                                        state_q <= S_ADDR_ACK;
                                        sda_q   <= 1'b1;
                                    end else begin
                                        sh_q  <= {sh_q[6:0], 1'b0};
                                        sda_q <= sh_q[6];
                                    end
                                end else if (state_q == S_ADDR_ACK) begin
                                    if (!sh_q[0]) begin
                                        state_q <= S_READ;
                                        sda_q   <= 1'b1;
                                        bit_q   <= '0;
                                        byte_q  <= '0;
                                    end else begin
                                        error_q <= 1'b1;
                                        state_q <= S_STOP;
                                        sda_q   <= 1'b0;
                                    end
                                end else if (state_q == S_READ) begin
                                    bit_q <= bit_q + 3'd1;
                                    if (bit_q == 3'd7) begin
                                        state_q <= S_MACK;
                                        // NACK the final byte so the slave releases the bus
                                        sda_q   <= last_byte;
                                        if (byte_q[0]) begin
                                            acc_q <= acc_d;
                                        end else begin
                                            a_q <= $signed(sh_q);
                                        end
                                    end
                                end else begin
                                    if (last_byte) begin
                                        state_q <= S_STOP;
                                        sda_q   <= 1'b0;
                                    end else begin
                                        state_q <= S_READ;
                                        sda_q   <= 1'b1;
                                        bit_q   <= '0;
                                        byte_q  <= byte_q + 9'd1;
                                    end
                                end
                            end
                        end
                        S_STOP: begin
                            if (phase_q == 3'd1) begin
                                scl_q <= 1'b1;
                            end
                            if (phase_q == 3'd3) begin
                                sda_q <= 1'b1;
                            end
                            if (phase_q == 3'd5) begin
                                state_q <= S_IDLE;
                                phase_q <= '0;
                                busy_q  <= 1'b0;
                                // Aborted or NACKed jobs leave the previous result on display
                                if (!abort_q && !error_q) begin
                                    done_q <= 1'b1;
                                    leds_q <= (relu_q && acc_q[ACC_W-1]) ? '0 : acc_q[LED_SHIFT +: LED_W];
                                end
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // Registered state drives the ports directly
    always_comb begin
        SDA   = sda_q;
        SCL   = scl_q;
        LEDs  = leds_q;
        busy  = busy_q;
        done  = done_q;
        error = error_q;
    end

endmodule

// File: tb/tb_npu_i2c_mac.sv
// Bench for npu_i2c_mac: two instances (A: VEC_LEN=2 CLK_DIV=2 ACC_W=24, B: VEC_LEN=4 CLK_DIV=1 ACC_W=16)
// share one I2C slave memory model through a bus select; vector table plus scoreboard,
// then hand-written abort and reset-mid-read sequences.
module tb_npu_i2c_mac;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1, start = 1'b0, stop = 1'b0, relu_en = 1'b0, sda_in = 1'b1;
    logic sel = 1'b0, nack_mode = 1'b0;

    logic start_a, start_b, stop_a, stop_b;
    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign stop_a  = stop & ~sel;
    assign stop_b  = stop & sel;

    logic       sda_a, scl_a, busy_a, done_a, err_a;
    logic       sda_b, scl_b, busy_b, done_b, err_b;
    logic [7:0] led_a, led_b;

    npu_i2c_mac #(.VEC_LEN(2), .CLK_DIV(2), .DEV_ADDR(7'h50), .ACC_W(24), .LED_W(8), .LED_SHIFT(0)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .stop(stop_a), .relu_en(relu_en),
        .SDA_in(sda_in), .SDA(sda_a), .SCL(scl_a), .LEDs(led_a),
        .busy(busy_a), .done(done_a), .error(err_a)
    );

    npu_i2c_mac #(.VEC_LEN(4), .CLK_DIV(1), .DEV_ADDR(7'h50), .ACC_W(16), .LED_W(8), .LED_SHIFT(0)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .stop(stop_b), .relu_en(relu_en),
        .SDA_in(sda_in), .SDA(sda_b), .SCL(scl_b), .LEDs(led_b),
        .busy(busy_b), .done(done_b), .error(err_b)
    );

    logic       sda_m, scl_m, busy_m, done_m, err_m;
    logic [7:0] led_m;
    assign sda_m  = sel ? sda_b  : sda_a;
    assign scl_m  = sel ? scl_b  : scl_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign err_m  = sel ? err_b  : err_a;
    assign led_m  = sel ? led_b  : led_a;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- I2C slave memory model ----------------
    logic [7:0] mem [8];
    logic [7:0] addr_sh = 8'h00, addr_cap = 8'h00;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, in_xfer = 1'b0;
    int nrise = 0, starts = 0, stops = 0, dclk = 0, macks = 0, nacks = 0;
    int pend = 0;  // classification of the last rising SCL, committed on the following fall

    always @(negedge clock) begin
        if (scl_m && prev_scl && prev_sda && !sda_m) begin
            starts++; in_xfer = 1'b1; nrise = 0; pend = 0; sda_in = 1'b1; addr_sh = 8'h00;
        end else if (scl_m && prev_scl && !prev_sda && sda_m) begin
            stops++; in_xfer = 1'b0; pend = 0; sda_in = 1'b1;
        end else if (in_xfer && scl_m && !prev_scl) begin
            if (nrise < 8) begin
                addr_sh = {addr_sh[6:0], sda_m};
                if (nrise == 7) addr_cap = addr_sh;
            end else if (nrise >= 9) begin
                pend = (((nrise - 9) % 9) == 8) ? (sda_m ? 3 : 2) : 1;
            end
            nrise++;
        end else if (in_xfer && !scl_m && prev_scl) begin
            if (pend == 1) dclk++;
            else if (pend == 2) macks++;
            else if (pend == 3) nacks++;
            pend = 0;
            if (nrise == 8) sda_in = nack_mode;
            else if (nrise >= 9 && ((nrise - 9) % 9) != 8 && ((nrise - 9) / 9) < 8)
                sda_in = mem[(nrise - 9) / 9][7 - ((nrise - 9) % 9)];
            else sda_in = 1'b1;
        end
        prev_scl = scl_m;
        prev_sda = sda_m;
    end

    // ---------------- vector table + scoreboard ----------------
    typedef struct {
        logic        sel;
        logic [63:0] bytes;   // byte k at [63-8k -: 8]
        logic        relu;
        logic        nack;
        logic        hold;
        logic [7:0]  led;
        logic        done;
        logic        err;
        int          dclk;
        int          macks;
        int          nacks;
    } vec_t;

    vec_t vt [6];
    vec_t sb [$];

    task automatic run_vec(input int i);
        vec_t v;
        vec_t e;
        int n, s0, p0, d0, m0, k0;
        v = vt[i];
        sel = v.sel; relu_en = v.relu; nack_mode = v.nack;
        for (int k = 0; k < 8; k++) mem[k] = v.bytes[63 - 8 * k -: 8];
        @(negedge clock);
        s0 = starts; p0 = stops; d0 = dclk; m0 = macks; k0 = nacks;
        start = 1'b1;
        sb.push_back(v);
        @(negedge clock);
        chk($sformatf("v%0d busy_rise", i), busy_m, 1);
        chk($sformatf("v%0d done_clr", i), done_m, 0);
        if (!v.hold) start = 1'b0;
        n = 0;
        while (busy_m && n < 8000) begin @(negedge clock); n++; end
        start = 1'b0;
        chk($sformatf("v%0d busy_fall", i), busy_m, 0);
        e = sb.pop_front();
        chk($sformatf("v%0d leds", i), led_m, e.led);
        chk($sformatf("v%0d done", i), done_m, e.done);
        chk($sformatf("v%0d error", i), err_m, e.err);
        chk($sformatf("v%0d addr_byte", i), addr_cap, 8'hA1);
        chk($sformatf("v%0d start_conds", i), starts - s0, 1);
        chk($sformatf("v%0d stop_conds", i), stops - p0, 1);
        chk($sformatf("v%0d read_clocks", i), dclk - d0, e.dclk);
        chk($sformatf("v%0d master_acks", i), macks - m0, e.macks);
        chk($sformatf("v%0d master_nacks", i), nacks - k0, e.nacks);
        if (v.hold) begin
            repeat (6) @(negedge clock);
            chk($sformatf("v%0d hold_no_restart", i), busy_m, 0);
            chk($sformatf("v%0d hold_done_kept", i), done_m, 1);
            chk($sformatf("v%0d hold_one_start", i), starts - s0, 1);
        end
    endtask

    initial begin
        int n, p0, d0;
        vt[0] = '{sel:1'b0, bytes:{8'd3, 8'd4, 8'hFE, 8'd5, 32'h0}, relu:1'b0, nack:1'b0, hold:1'b0,
                  led:8'h02, done:1'b1, err:1'b0, dclk:32, macks:3, nacks:1};
        vt[1] = '{sel:1'b0, bytes:{8'hFD, 8'd4, 8'd1, 8'd1, 32'h0}, relu:1'b1, nack:1'b0, hold:1'b0,
                  led:8'h00, done:1'b1, err:1'b0, dclk:32, macks:3, nacks:1};
        vt[2] = '{sel:1'b0, bytes:{8'hFD, 8'd4, 8'd1, 8'd1, 32'h0}, relu:1'b0, nack:1'b0, hold:1'b0,
                  led:8'hF5, done:1'b1, err:1'b0, dclk:32, macks:3, nacks:1};
        vt[3] = '{sel:1'b0, bytes:{8'd3, 8'd4, 8'hFE, 8'd5, 32'h0}, relu:1'b0, nack:1'b1, hold:1'b0,
                  led:8'hF5, done:1'b0, err:1'b1, dclk:0, macks:0, nacks:0};
        vt[4] = '{sel:1'b1, bytes:{8{8'h7F}}, relu:1'b0, nack:1'b0, hold:1'b1,
                  led:8'h04, done:1'b1, err:1'b0, dclk:64, macks:7, nacks:1};
        vt[5] = '{sel:1'b1, bytes:{8{8'h7F}}, relu:1'b1, nack:1'b0, hold:1'b0,
                  led:8'h00, done:1'b1, err:1'b0, dclk:64, macks:7, nacks:1};

        // Reset values on both instances
        repeat (3) @(negedge clock);
        chk("rst_sda_a", sda_a, 1);  chk("rst_scl_a", scl_a, 1);
        chk("rst_leds_a", led_a, 0); chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0); chk("rst_err_a", err_a, 0);
        chk("rst_sda_b", sda_b, 1);  chk("rst_leds_b", led_b, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // start together with stop is refused
        sel = 1'b0; start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        @(negedge clock);
        chk("start_with_stop_idle", busy_a, 0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Abort during the second data byte
        sel = 1'b0; relu_en = 1'b0; nack_mode = 1'b0;
        for (int k = 0; k < 8; k++) mem[k] = vt[0].bytes[63 - 8 * k -: 8];
        @(negedge clock);
        p0 = stops;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (nrise < 19 && n < 4000) begin @(negedge clock); n++; end
        chk("abort_reached_byte1", (nrise >= 19) ? 1 : 0, 1);
        d0 = dclk;
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
        n = 1;
        while (sda_a && n < 20) begin @(negedge clock); n++; end
        chk("abort_within_quarter", (n <= 3) ? 1 : 0, 1);
        n = 0;
        while (busy_a && n < 200) begin @(negedge clock); n++; end
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_error", err_a, 0);
        chk("abort_leds_kept", led_a, 8'hF5);
        chk("abort_stop_cond", stops - p0, 1);
        chk("abort_byte1_cut", (dclk - d0 < 8) ? 1 : 0, 1);

        // A fresh job after the abort completes normally
        run_vec(0);

        // Reset in the middle of a read
        sel = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (nrise < 12 && n < 4000) begin @(negedge clock); n++; end
        chk("midread_busy", busy_a, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_sda", sda_a, 1);
        chk("midrst_scl", scl_a, 1);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_leds", led_a, 0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("midrst_stays_idle", busy_a, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
